pilha_rpn: RTL and testbench
============================

# pilha_rpn

Operand stack for the RPN ALU datapath: a LIFO of `PROFUNDIDADE` words, each `LARGURA` bits wide. It accepts push, pop, replace-top and binary-reduce commands, one per clock. The ALU reads its operands from the stack rather than writing them into standalone load-enabled registers. The block exposes the top two entries combinationally as ALU operands, and reports depth, full/empty status and a sticky error flag.

## Interface
- `LARGURA`, default 8: data word width.
- `PROFUNDIDADE`, default 4: number of entries; legal range 2..15.
- `PW`, default 3: width of the depth count; must satisfy 2^PW > `PROFUNDIDADE`.
- `CLOCK` input, 1 bit: single clock; all state changes on the rising edge.
- `RESET` input, 1 bit: synchronous, active-high reset.
- `D` input, `LARGURA` bits: data for push, replace and binary-reduce.
- `PUSH` input, 1 bit: push `D`.
- `POP` input, 1 bit: discard the top entry.
- `BINOP` input, 1 bit: remove the top two entries and push `D`, which carries the ALU result.
- `LIMPA_ERRO` input, 1 bit: clear `ERRO`.
- `TOPO` output, `LARGURA` bits: top entry; 0 when empty.
- `SEGUNDO` output, `LARGURA` bits: entry below the top; 0 when depth < 2.
- `PROF` output, `PW` bits: current depth, 0..`PROFUNDIDADE`.
- `VAZIA` output, 1 bit: depth == 0.
- `CHEIA` output, 1 bit: depth == `PROFUNDIDADE`.
- `ERRO` output, 1 bit: sticky error flag.

## Operation
- **Reset.** When `RESET`=1 at an edge, all entries, depth and `ERRO` go to 0. After reset, `TOPO`=0, `SEGUNDO`=0, `PROF`=0, `VAZIA`=1, `CHEIA`=0, `ERRO`=0. `RESET` overrides every command in the same cycle, including mid-sequence.
- **Command decode** on each edge, with `RESET`=0:
  - No command asserted: hold all state.
  - `PUSH` only: if depth < `PROFUNDIDADE`, write `D` as the new top and add 1 to depth; else error.
  - `POP` only: if depth ≥ 1, subtract 1 from depth; else error.
  - `PUSH`+`POP` (replace): if depth ≥ 1, overwrite the top with `D`; depth unchanged; else error.
  - `BINOP` only: if depth ≥ 2, the new top is `D` and depth is reduced by 1; the entry below the old second entry becomes the new `SEGUNDO`. Otherwise error.
  - `BINOP` combined with `PUSH` or `POP`: illegal, raise error.
- **Error cycles.** Any error condition leaves entries and depth unchanged and sets `ERRO` to 1.
- **Clearing errors.** `ERRO` stays 1 until `RESET`, or until `LIMPA_ERRO`=1 at an edge. If `LIMPA_ERRO` and a new error condition occur in the same cycle, `ERRO` stays 1 (the error wins).
- **Popped contents.** Entries above the depth pointer are don't-care internally. They must never appear on `TOPO` or `SEGUNDO`; the 0 masking for depth 0 or 1 is mandatory.
- **Arithmetic.** No arithmetic is done on data. Depth arithmetic is unsigned `PW`-bit and never wraps: an overflow or underflow attempt is an error, not a wrap.
- **Implementation choice.** Either a shift-register or a pointer-addressed array is acceptable, provided the observable behaviour above is met exactly.

## Timing
- All outputs are functions of registered state only; there is no combinational path from `D` or the command inputs to any output.
- Latency: the effect of a command sampled at edge N is visible on the outputs right after edge N.
- Throughput: one command per cycle, back-to-back, with no bubbles. A push at edge N followed by a pop at edge N+1 restores the pre-N state.
- `VAZIA`, `CHEIA` and `PROF` are always mutually consistent in the same cycle.
- Deassertion of `RESET` takes effect at the next edge; a command presented with `RESET`=0 at that edge executes normally.

## Test plan
1. **Reset.** Assert `RESET` for 2 cycles with `PUSH`=1 and `D`=0xAA. Expect `PROF`=0, `VAZIA`=1, `TOPO`=0, `ERRO`=0.
2. **Fill and overflow.**
   - Push 0x11, 0x22, 0x33, 0x44. Expect `CHEIA`=1, `TOPO`=0x44, `SEGUNDO`=0x33, `PROF`=4.
   - Push 0x55. Expect `ERRO`=1 with all contents unchanged.
3. **Binary reduce.**
   - From [0x11,0x22,0x33,0x44], apply `BINOP` with `D`=0x77. Expect `TOPO`=0x77, `SEGUNDO`=0x22, `PROF`=3.
   - Apply `BINOP` with `D`=0x99. Expect `TOPO`=0x99, `SEGUNDO`=0x11, `PROF`=2.
4. **Underflow.**
   - At depth 1 with `TOPO`=0x05, apply `BINOP`. Expect `ERRO`=1, `TOPO`=0x05, `SEGUNDO`=0.
   - Pop twice. Expect the first pop to give `VAZIA`=1 and the second to leave `PROF`=0 with `ERRO` still 1.
5. **Replace and illegal combination.**
   - At depth 2 with [0x10,0x20], apply `PUSH`+`POP` with `D`=0x2F. Expect `TOPO`=0x2F, `PROF`=2.
   - Apply `BINOP`+`POP`. Expect `ERRO`=1 with the state unchanged.
6. **Error clear.**
   - With `ERRO`=1, apply `LIMPA_ERRO`. Expect `ERRO`=0.
   - With the stack empty, apply `LIMPA_ERRO`+`POP`. Expect `ERRO` to stay 1.
   - Apply `RESET` mid-sequence at depth 3. Expect all outputs back at their reset values after the edge.

Source files
------------

// File: rtl/pilha_rpn.sv
// Operand stack for the RPN ALU: a LIFO of PROFUNDIDADE words that accepts
// push, pop, replace-top and binary-reduce commands, one per clock. The top
// two entries are presented as ALU operands; depth, full/empty and a sticky
// error flag are reported alongside. All outputs come from registered state.
module pilha_rpn #(
    parameter int LARGURA      = 8,
    parameter int PROFUNDIDADE = 4,
    parameter int PW           = 3
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [LARGURA-1:0] D,
    input  logic               PUSH,
    input  logic               POP,
    input  logic               BINOP,
    input  logic               LIMPA_ERRO,
    output logic [LARGURA-1:0] TOPO,
    output logic [LARGURA-1:0] SEGUNDO,
    output logic [PW-1:0]      PROF,
    output logic               VAZIA,
    output logic               CHEIA,
    output logic               ERRO
);

    localparam logic [PW-1:0] PROF_MAX = PW'(PROFUNDIDADE);
    localparam logic [PW-1:0] UM       = PW'(1);
    localparam logic [PW-1:0] DOIS     = PW'(2);

    typedef enum logic [2:0] {
        CMD_NADA,
        CMD_PUSH,
        CMD_POP,
        CMD_TROCA,
        CMD_BINOP,
        CMD_ILEGAL
    } cmd_t;

    // Entry 0 is the bottom of the stack; the top lives at index prof_q-1.
    logic [LARGURA-1:0] mem [PROFUNDIDADE];
    logic [PW-1:0]      prof_q;
    logic               erro_q;

    cmd_t               cmd;
    logic               falha;
    logic               escreve;
    logic [PW-1:0]      idx_esc;
    logic [PW-1:0]      prof_nxt;

    // Classify the command lines into a single operation.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        cmd = CMD_ILEGAL;
        case ({BINOP, PUSH, POP})
            3'b000:  cmd = CMD_NADA;
            3'b010:  cmd = CMD_PUSH;
            3'b001:  cmd = CMD_POP;
            3'b011:  cmd = CMD_TROCA;
            3'b100:  cmd = CMD_BINOP;
            default: cmd = CMD_ILEGAL;
        endcase
    end

    // Decide the write slot, next depth and whether this cycle is an error.
    // An error leaves entries and depth untouched.
    always_comb begin
        falha    = 1'b0;
        escreve  = 1'b0;
        idx_esc  = '0;
        prof_nxt = prof_q;
        case (cmd)
            CMD_NADA: ;
            CMD_PUSH: begin
                if (prof_q < PROF_MAX) begin
                    escreve  = 1'b1;
                    idx_esc  = prof_q;
                    prof_nxt = prof_q + UM;
                end else begin
                    falha = 1'b1;
                end
            end
            CMD_POP: begin
                if (prof_q >= UM) prof_nxt = prof_q - UM;
                else              falha    = 1'b1;
            end
            CMD_TROCA: begin
                if (prof_q >= UM) begin
                    escreve = 1'b1;
                    idx_esc = prof_q - UM;
                end else begin
                    falha = 1'b1;
                end
            end
            CMD_BINOP: begin
                // The ALU result replaces the old second entry, which becomes
                // the new top once depth drops by one.
                if (prof_q >= DOIS) begin
                    escreve  = 1'b1;
                    idx_esc  = prof_q - DOIS;
                    prof_nxt = prof_q - UM;
                end else begin
                    falha = 1'b1;
                end
            end
            default: falha = 1'b1;
        endcase
    end

    // State update: entries, depth and the sticky error flag.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            prof_q <= '0;
            erro_q <= 1'b0;
            // NOTE: the entries are cleared on reset because the stack must come
            // up all-zero; popped slots are masked on the outputs anyway.
            for (int i = 0; i < PROFUNDIDADE; i++) mem[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the pre-edge values regardless of statement order.
            prof_q <= prof_nxt;
            if (escreve) begin
                for (int i = 0; i < PROFUNDIDADE; i++) begin
                    if (PW'(i) == idx_esc) mem[i] <= D;
                end
            end
            // A new error wins over a simultaneous clear request.
            erro_q <= falha | (erro_q & ~LIMPA_ERRO);
        end
    end

    // Present the top two entries, forced to zero when not present.
    always_comb begin
        TOPO    = '0;
        SEGUNDO = '0;
        for (int i = 0; i < PROFUNDIDADE; i++) begin
            if (prof_q >= UM   && PW'(i) == prof_q - UM)   TOPO    = mem[i];
            if (prof_q >= DOIS && PW'(i) == prof_q - DOIS) SEGUNDO = mem[i];
        end
    end

    assign PROF  = prof_q;
    assign VAZIA = (prof_q == '0);
    assign CHEIA = (prof_q == PROF_MAX);
    assign ERRO  = erro_q;

endmodule

// File: tb/tb_pilha_rpn.sv
// Directed bench for pilha_rpn: walks reset, fill/overflow, binary reduce,
// underflow, replace, illegal combinations and error clearing.
module tb_pilha_rpn;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic [7:0] D;
    logic       PUSH, POP, BINOP, LIMPA_ERRO;
    logic [7:0] TOPO, SEGUNDO;
    logic [2:0] PROF;
    logic       VAZIA, CHEIA, ERRO;

    int total = 0;
    int bad   = 0;

    pilha_rpn #(.LARGURA(8), .PROFUNDIDADE(4), .PW(3)) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .D          (D),
        .PUSH       (PUSH),
        .POP        (POP),
        .BINOP      (BINOP),
        .LIMPA_ERRO (LIMPA_ERRO),
        .TOPO       (TOPO),
        .SEGUNDO    (SEGUNDO),
        .PROF       (PROF),
        .VAZIA      (VAZIA),
        .CHEIA      (CHEIA),
        .ERRO       (ERRO)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one command across a rising edge, then settle 1 time unit.
    task automatic step(input logic rst, input logic push, input logic pop,
                        input logic binop, input logic limpa, input logic [7:0] d);
        RESET      = rst;
        PUSH       = push;
        POP        = pop;
        BINOP      = binop;
        LIMPA_ERRO = limpa;
        D          = d;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [7:0] topo, input logic [7:0] seg,
                               input logic [2:0] prof, input logic erro);
        check({tag, ".topo"}, 32'(TOPO), 32'(topo));
        check({tag, ".seg"},  32'(SEGUNDO), 32'(seg));
        check({tag, ".prof"}, 32'(PROF), 32'(prof));
        check({tag, ".vazia"}, 32'(VAZIA), 32'(prof == 3'd0));
        check({tag, ".cheia"}, 32'(CHEIA), 32'(prof == 3'd4));
        check({tag, ".erro"}, 32'(ERRO), 32'(erro));
    endtask

    initial begin
        // 1. Reset held two cycles with a push request that must be ignored.
        step(1, 1, 0, 0, 0, 8'hAA);
        step(1, 1, 0, 0, 0, 8'hAA);
        check_state("reset", 8'h00, 8'h00, 3'd0, 1'b0);

        // 2. Fill, checking second-entry masking at depth 1, then overflow.
        step(0, 1, 0, 0, 0, 8'h11);
        check_state("push1", 8'h11, 8'h00, 3'd1, 1'b0);
        step(0, 1, 0, 0, 0, 8'h22);
        step(0, 1, 0, 0, 0, 8'h33);
        step(0, 1, 0, 0, 0, 8'h44);
        check_state("full", 8'h44, 8'h33, 3'd4, 1'b0);
        step(0, 1, 0, 0, 0, 8'h55);
        check_state("overflow", 8'h44, 8'h33, 3'd4, 1'b1);

        // 3. Binary reduce twice (error flag remains sticky throughout).
        step(0, 0, 0, 1, 0, 8'h77);
        check_state("binop1", 8'h77, 8'h22, 3'd3, 1'b1);
        step(0, 0, 0, 1, 0, 8'h99);
        check_state("binop2", 8'h99, 8'h11, 3'd2, 1'b1);

        // Clear the error with an idle command.
        step(0, 0, 0, 0, 1, 8'h00);
        check_state("clear1", 8'h99, 8'h11, 3'd2, 1'b0);

        // 4. Underflow: depth 1 holding 0x05, then BINOP and two pops.
        step(0, 0, 1, 0, 0, 8'h00);
        check_state("pop_to1", 8'h11, 8'h00, 3'd1, 1'b0);
        step(0, 1, 1, 0, 0, 8'h05);
        check_state("repl05", 8'h05, 8'h00, 3'd1, 1'b0);
        step(0, 0, 0, 1, 0, 8'hEE);
        check_state("binop_under", 8'h05, 8'h00, 3'd1, 1'b1);
        step(0, 0, 1, 0, 0, 8'h00);
        check_state("pop_empty", 8'h00, 8'h00, 3'd0, 1'b1);
        step(0, 0, 1, 0, 0, 8'h00);
        check_state("pop_under", 8'h00, 8'h00, 3'd0, 1'b1);

        // Replace on an empty stack is also an error.
        step(0, 1, 1, 0, 0, 8'h66);
        check_state("repl_empty", 8'h00, 8'h00, 3'd0, 1'b1);

        // 5. Replace at depth 2, then illegal BINOP+POP / BINOP+PUSH.
        step(0, 1, 0, 0, 1, 8'h10);
        check_state("push10_clr", 8'h10, 8'h00, 3'd1, 1'b0);
        step(0, 1, 0, 0, 0, 8'h20);
        step(0, 1, 1, 0, 0, 8'h2F);
        check_state("replace", 8'h2F, 8'h10, 3'd2, 1'b0);
        step(0, 0, 1, 1, 0, 8'h3E);
        check_state("binop_pop", 8'h2F, 8'h10, 3'd2, 1'b1);
        step(0, 0, 0, 0, 1, 8'h00);
        check_state("clear2", 8'h2F, 8'h10, 3'd2, 1'b0);
        step(0, 1, 0, 1, 0, 8'h3E);
        check_state("binop_push", 8'h2F, 8'h10, 3'd2, 1'b1);

        // 6. Error clear and error-wins-over-clear.
        step(0, 0, 0, 0, 1, 8'h00);
        check_state("clear3", 8'h2F, 8'h10, 3'd2, 1'b0);
        step(0, 0, 1, 0, 0, 8'h00);
        step(0, 0, 1, 0, 0, 8'h00);
        check_state("drained", 8'h00, 8'h00, 3'd0, 1'b0);
        step(0, 0, 1, 0, 1, 8'h00);
        check_state("clr_and_err", 8'h00, 8'h00, 3'd0, 1'b1);

        // Push then pop restores the prior state; stale data stays hidden.
        step(0, 1, 0, 0, 0, 8'h3C);
        check_state("push3c", 8'h3C, 8'h00, 3'd1, 1'b1);
        step(0, 0, 1, 0, 0, 8'h00);
        check_state("pop3c", 8'h00, 8'h00, 3'd0, 1'b1);

        // Mid-sequence reset at depth 3, then a push on the release edge.
        step(0, 1, 0, 0, 1, 8'h01);
        step(0, 1, 0, 0, 0, 8'h02);
        step(0, 1, 0, 0, 0, 8'h03);
        check_state("depth3", 8'h03, 8'h02, 3'd3, 1'b0);
        step(1, 1, 0, 0, 0, 8'hAA);
        check_state("midreset", 8'h00, 8'h00, 3'd0, 1'b0);
        step(0, 1, 0, 0, 0, 8'h5A);
        check_state("post_reset", 8'h5A, 8'h00, 3'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
